// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - core ALU command/immediate types plus macro-op codes for the sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_NAND = 2'd1,
        ALU_SHFT = 2'd2
    } alu_cmd_t;

    // flag = 1 selects a right shift; shamt is the shift distance
    typedef struct packed {
        logic       flag;
        logic [2:0] shamt;
    } immed_t;

    localparam immed_t IMM_NONE = '{flag: 1'b0, shamt: 3'd0};
    localparam immed_t SHL1     = '{flag: 1'b0, shamt: 3'd1};
    localparam immed_t SHR1     = '{flag: 1'b1, shamt: 3'd1};

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_NOT = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SUB = 3'd4,
        OP_MUL = 3'd5
    } seq_op_t;

    localparam logic [1:0] STEPS_ADD = 2'd1;
    localparam logic [1:0] STEPS_NOT = 2'd1;
    localparam logic [1:0] STEPS_AND = 2'd2;
    localparam logic [1:0] STEPS_OR  = 2'd3;
    localparam logic [1:0] STEPS_SUB = 2'd3;

    function automatic logic [1:0] steps_of(input logic [2:0] op);
        case (op)
            OP_ADD:  return STEPS_ADD;
            OP_NOT:  return STEPS_NOT;
            OP_AND:  return STEPS_AND;
            OP_OR:   return STEPS_OR;
            OP_SUB:  return STEPS_SUB;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle macro-op sequencer driving the 8-bit ADD/NAND/SHFT ALU
// ALU_SEQ_MUL_EN builds the shift-add MUL loop; without it MUL reports an error.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [D-1:0]   in_a,
    input  logic [D-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D-1:0]   out_x,
    output logic           out_err,
    output logic [D-1:0]   alu_a,
    output logic [D-1:0]   alu_b,
    output logic [3:0]     alu_n,
    output alu_cmd_t       alu_cmd,
    input  logic [D-1:0]   alu_x
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DONE, S_MADD, S_MSHL, S_MSHR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state;
    logic [2:0]   op;
    logic [1:0]   step;
    logic [D-1:0] a, b, t, u;
`ifdef ALU_SEQ_MUL_EN
    logic [D-1:0] acc, ma, mb;
`endif

    logic last_step;
    assign last_step = (step == steps_of(op) - 2'd1);

    always_comb begin
        alu_cmd = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        alu_n   = IMM_NONE;
        case (state)
            S_EXEC: begin
                case (op)
                    OP_ADD: begin alu_cmd = ALU_ADD;  alu_a = a; alu_b = b; end
                    OP_NOT: begin alu_cmd = ALU_NAND; alu_a = a; alu_b = a; end
                    OP_AND: begin
                        alu_cmd = ALU_NAND;
                        alu_a   = (step == 2'd0) ? a : t;
                        alu_b   = (step == 2'd0) ? b : t;
                    end
                    OP_OR: begin
                        alu_cmd = ALU_NAND;
                        case (step)
                            2'd0:    begin alu_a = a; alu_b = a; end
                            2'd1:    begin alu_a = b; alu_b = b; end
                            default: begin alu_a = t; alu_b = u; end
                        endcase
                    end
                    OP_SUB: begin
                        // two's complement: ~B, then A + ~B, then + 1
                        case (step)
                            2'd0:    begin alu_cmd = ALU_NAND; alu_a = b; alu_b = b; end
                            2'd1:    begin alu_cmd = ALU_ADD;  alu_a = a; alu_b = t; end
                            default: begin alu_cmd = ALU_ADD;  alu_a = t; alu_b = ONE; end
                        endcase
                    end
                    default: ;
                endcase
            end
`ifdef ALU_SEQ_MUL_EN
            S_MADD: if (mb[0]) begin alu_cmd = ALU_ADD; alu_a = acc; alu_b = ma; end
            S_MSHL: begin alu_cmd = ALU_SHFT; alu_a = ma; alu_n = SHL1; end
            S_MSHR: begin alu_cmd = ALU_SHFT; alu_a = mb; alu_n = SHR1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_err   <= 1'b0;
            op        <= '0;
            step      <= '0;
            a         <= '0;
            b         <= '0;
            t         <= '0;
            u         <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op       <= in_op;
                    a        <= in_a;
                    b        <= in_b;
                    step     <= 2'd0;
                    in_ready <= 1'b0;
                    if (in_op <= 3'(OP_SUB)) begin
                        state <= S_EXEC;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (in_op == 3'(OP_MUL)) begin
                        if (in_b == '0) begin
                            out_x     <= '0;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            acc   <= '0;
                            ma    <= in_a;
                            mb    <= in_b;
                            state <= S_MADD;
                        end
                    end
`endif
                    else begin
                        out_x     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_EXEC: begin
                    if (last_step) begin
                        out_x     <= alu_x;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        if (op == 3'(OP_OR) && step == 2'd1) u <= alu_x;
                        else                                 t <= alu_x;
                        step <= step + 2'd1;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MADD: begin
                    if (mb[0]) acc <= alu_x;
                    state <= S_MSHL;
                end
                S_MSHL: begin
                    ma    <= alu_x;
                    state <= S_MSHR;
                end
                S_MSHR: begin
                    mb <= alu_x;
                    if (alu_x == '0) begin
                        out_x     <= acc;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_MADD;
                    end
                end
`endif
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
